fp_int_seq_ctrl: RTL and testbench
==================================

# fp_int_seq_ctrl

Bit-serial operand scheduler for the fp16 × intN multiplier. It accepts whole (activation, weight, precision) operations through a ready/valid port and buffers them in a 2-entry FIFO. It streams each weight MSB-first, one bit per cycle, into the multiplier's `act`/`w`/`valid`/`precision` inputs, holding the activation stable for the whole operation. It sits between the PE-array operand loader and the multiplier, and signals completion of each operation to the downstream accumulator control.

## Interface
- `ACT_WIDTH`, 16, activation width (fp16: sign, 5-bit exponent, 10-bit mantissa).
- `W_MAX`, 8, maximum weight width in bits; legal precision range is 2..`W_MAX`.
- `clk`  input  1  clock, all state on rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `in_valid`  input  1  operation offered.
- `in_ready`  output  1  FIFO not full; equals !full.
- `in_act`  input  `ACT_WIDTH`  activation.
- `in_w`  input  `W_MAX`  two's-complement weight, right-aligned; bits above precision-1 ignored.
- `in_prec`  input  4  weight precision in bits.
- `mul_valid`  output  1  multiplier valid.
- `mul_act`  output  `ACT_WIDTH`  activation to multiplier.
- `mul_w`  output  1  current weight bit.
- `mul_prec`  output  4  precision to multiplier (effective, after clamping).
- `op_done`  output  1  one-cycle pulse, the cycle after the last bit of an operation.
- `busy`  output  1  FIFO non-empty or streaming.
- `prec_err`  output  1  sticky: an operation was accepted with an illegal in_prec.

## Operation
- Acceptance:
  - An operation is accepted on an edge with in_valid && in_ready; it is written to the FIFO tail.
  - in_ready depends only on FIFO occupancy, never on same-cycle pop.
- Precision clamp at acceptance:
  - in_prec < 2 → 2; in_prec > `W_MAX` → `W_MAX`.
  - Either case sets prec_err; prec_err is cleared only by rst.
- FSM states:
  - IDLE:
    - mul_valid=0.
    - FIFO non-empty → LOAD head into the shift register and bit counter, go to STREAM.
  - STREAM:
    - mul_valid=1; mul_act and mul_prec are held from the head entry.
    - mul_w = weight bit (prec-1-k) in cycle k of the operation, so the sign bit comes first.
    - On the last bit (k = prec-1):
      - pop the FIFO;
      - if the next head exists and has the same effective precision, load it and stay in STREAM, giving back-to-back bits with no bubble;
      - if the next head has a different precision → GAP;
      - if the FIFO is empty → IDLE.
  - GAP:
    - Exactly one cycle with mul_valid=0, which restarts the multiplier's bit counter.
    - Then load the head and go to STREAM.
- Loading from IDLE or GAP takes no extra cycle: the load happens on the transition edge.
- op_done pulses in the cycle after each operation's last bit, including when the next operation streams immediately.
- busy = FIFO non-empty || state != IDLE.
- Reset values:
  - in_ready=1; mul_valid=0, mul_act=0, mul_w=0, mul_prec=0; op_done=0, busy=0, prec_err=0.
  - FIFO empty; state IDLE.
- Reset mid-stream aborts the current operation immediately, with no op_done, and discards FIFO contents.

## Timing
- Latency: accept on edge t with the controller idle → first bit (mul_valid=1) in cycle t+1.
- An operation of precision P occupies exactly P consecutive mul_valid cycles.
- Throughput with uniform precision and a continuously fed FIFO: 100% mul_valid.
- A precision change costs 1 bubble cycle.
- FIFO full (2 entries): in_ready=0.
  - It rises the cycle after the pop edge.
  - An offer at the pop edge itself is not accepted.
- Push and pop on the same edge with 1 entry: occupancy stays 1 and the new entry becomes the next head.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: rst high mid-stream for 1 cycle.
  - mul_valid drops asynchronously; in_ready=1, busy=0, op_done=0.
  - The next accepted operation starts cleanly.
- Single operation: in_act=16'h3C00, in_w=4'b1011, in_prec=4, accepted at edge 0.
  - Cycles 1–4: mul_valid=1, mul_w=1,0,1,1, mul_act=16'h3C00, mul_prec=4.
  - Cycle 5: op_done=1, mul_valid=0.
- Back-to-back: three prec-4 operations offered continuously.
  - 12 contiguous mul_valid cycles.
  - op_done in cycles 5, 9, 13.
  - in_ready drops when 2 entries are queued.
- Precision change: prec-4 (w=4'hA) followed by prec-2 (w=2'b01).
  - mul_w = 1,0,1,0, then one mul_valid=0 cycle, then 0,1 with mul_prec=2.
- Clamp: in_prec=0, then in_prec=12 with `W_MAX`=8.
  - Streams of 2 and 8 bits respectively; prec_err=1 from the cycle after the first acceptance and stays set.
- Full FIFO with simultaneous offer at the pop edge: that offer is not accepted.
  - The same operation accepted one cycle later streams in order with no loss or duplication.

Source files
------------

// File: rtl/fp_int_seq_ctrl.sv
// fp_int_seq_ctrl
//
// Bit-serial operand scheduler for the fp16 x intN multiplier. Whole
// operations (activation, weight, precision) are queued in a 2-entry FIFO.
// Each weight is streamed MSB-first, one bit per cycle, while the activation
// and effective precision are held stable for the whole operation.
//
// Handshake: an operation is accepted on a rising edge where
// in_valid && in_ready. in_ready is !full and depends only on the registered
// FIFO occupancy, so a pop on the same edge never makes room for an offer.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operation offer / FIFO not full
//   in_act, in_w,       activation, right-aligned two's-complement weight,
//   in_prec             weight precision (clamped to 2..W_MAX at acceptance)
//   mul_valid, mul_act, registered multiplier inputs
//   mul_w, mul_prec
//   op_done             one-cycle pulse the cycle after an operation's last bit
//   busy                FIFO non-empty or controller not idle
//   prec_err            sticky: an illegal precision was accepted
module fp_int_seq_ctrl #(
    parameter int ACT_WIDTH = 16,
    parameter int W_MAX     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ACT_WIDTH-1:0] in_act,
    input  logic [W_MAX-1:0]     in_w,
    input  logic [3:0]           in_prec,
    output logic                 mul_valid,
    output logic [ACT_WIDTH-1:0] mul_act,
    output logic                 mul_w,
    output logic [3:0]           mul_prec,
    output logic                 op_done,
    output logic                 busy,
    output logic                 prec_err
);

    localparam int IW = (W_MAX > 1) ? $clog2(W_MAX) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [ACT_WIDTH-1:0] act_mem  [2];
    logic [W_MAX-1:0]     w_mem    [2];
    logic [3:0]           prec_mem [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           count;

    logic                 full;
    logic                 empty;
    logic                 has_next;
    logic                 push;
    logic                 pop;

    logic [3:0]           eff_prec;
    logic                 clamp_err;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign has_next = full;  // a second entry behind the streaming head
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign busy     = !empty || (state != IDLE);

    always_comb begin
        eff_prec  = in_prec;
        clamp_err = 1'b0;
        if (in_prec < 4'd2) begin
            eff_prec  = 4'd2;
            clamp_err = 1'b1;
        end else if (in_prec > 4'(W_MAX)) begin
            eff_prec  = 4'(W_MAX);
            clamp_err = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            act_mem[wr_ptr]  <= in_act;
            w_mem[wr_ptr]    <= in_w;
            prec_mem[wr_ptr] <= eff_prec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            prec_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
                if (clamp_err) begin
                    prec_err <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Streaming control
    // ------------------------------------------------------------------
    logic [W_MAX-1:0] w_reg;
    logic [3:0]       bit_left;   // bits still to present after the current one
    logic             last_bit;
    logic             load;

    // The head entry stays in the FIFO while it streams; during STREAM the
    // entry to load next is the one behind it.
    logic [ACT_WIDTH-1:0] src_act;
    logic [W_MAX-1:0]     src_w;
    logic [3:0]           src_prec;
    logic [IW-1:0]        ld_idx;
    logic [IW-1:0]        nxt_idx;

    assign last_bit = (state == STREAM) && (bit_left == 4'd0);
    assign pop      = last_bit;

    always_comb begin
        if (state == STREAM) begin
            src_act  = act_mem[~rd_ptr];
            src_w    = w_mem[~rd_ptr];
            src_prec = prec_mem[~rd_ptr];
        end else begin
            src_act  = act_mem[rd_ptr];
            src_w    = w_mem[rd_ptr];
            src_prec = prec_mem[rd_ptr];
        end
    end

    assign ld_idx  = IW'(src_prec - 4'd1);
    assign nxt_idx = IW'(bit_left - 4'd1);

    // Same-precision successors stream with no bubble; a precision change
    // goes through GAP so the multiplier sees one mul_valid=0 cycle.
    always_comb begin
        load = 1'b0;
        case (state)
            IDLE:    load = !empty;
            GAP:     load = !empty;
            STREAM:  load = last_bit && has_next && (src_prec == mul_prec);
            default: load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mul_valid <= 1'b0;
            mul_act   <= '0;
            mul_w     <= 1'b0;
            mul_prec  <= 4'd0;
            op_done   <= 1'b0;
            w_reg     <= '0;
            bit_left  <= 4'd0;
        end else begin
            op_done <= last_bit;
            if (load) begin
                state     <= STREAM;
                mul_valid <= 1'b1;
                mul_act   <= src_act;
                mul_prec  <= src_prec;
                mul_w     <= src_w[ld_idx];
                w_reg     <= src_w;
                bit_left  <= src_prec - 4'd1;
            end else begin
                case (state)
                    IDLE: begin
                        mul_valid <= 1'b0;
                        mul_w     <= 1'b0;
                    end
                    STREAM: begin
                        if (bit_left != 4'd0) begin
                            bit_left <= bit_left - 4'd1;
                            mul_w    <= w_reg[nxt_idx];
                        end else begin
                            mul_valid <= 1'b0;
                            mul_w     <= 1'b0;
                            state     <= has_next ? GAP : IDLE;
                        end
                    end
                    GAP: begin
                        mul_valid <= 1'b0;
                        mul_w     <= 1'b0;
                        state     <= IDLE;
                    end
                    default: begin
                        mul_valid <= 1'b0;
                        mul_w     <= 1'b0;
                        state     <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fp_int_seq_ctrl.sv
// Testbench for fp_int_seq_ctrl. Drivers push expected multiplier beats
// (cycle stamp, activation, precision, bit) and op_done cycle stamps into
// queues; a negedge monitor pops and compares whenever the DUT presents
// mul_valid or op_done.
module tb_fp_int_seq_ctrl;
  localparam int ACT_WIDTH = 16;
  localparam int W_MAX     = 8;
  localparam int EW        = 16 + ACT_WIDTH + 4 + 1;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [ACT_WIDTH-1:0] in_act;
  logic [W_MAX-1:0]     in_w;
  logic [3:0]           in_prec;
  logic                 mul_valid;
  logic [ACT_WIDTH-1:0] mul_act;
  logic                 mul_w;
  logic [3:0]           mul_prec;
  logic                 op_done;
  logic                 busy;
  logic                 prec_err;

  fp_int_seq_ctrl #(.ACT_WIDTH(ACT_WIDTH), .W_MAX(W_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_act    (in_act),
    .in_w      (in_w),
    .in_prec   (in_prec),
    .mul_valid (mul_valid),
    .mul_act   (mul_act),
    .mul_w     (mul_w),
    .mul_prec  (mul_prec),
    .op_done   (op_done),
    .busy      (busy),
    .prec_err  (prec_err)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [15:0]   done_q[$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected beats for one operation: bit prec-1-k in cycle start+k, then
  // op_done in cycle start+prec.
  task automatic exp_op(input int start, input logic [15:0] act, input logic [7:0] w, input int prec);
    for (int k = 0; k < prec; k++)
      exp_q.push_back({16'(start + k), act, 4'(prec), w[prec - 1 - k]});
    done_q.push_back(16'(start + prec));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [15:0]   d;
    if (mul_valid) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL beat: unexpected mul_valid at cycle %0d act=%0h prec=%0d w=%0b", cyc, mul_act, mul_prec, mul_w);
      end else begin
        e = exp_q.pop_front();
        if ({16'(cyc), mul_act, mul_prec, mul_w} === e) n_pass++;
        else $display("FAIL beat: got cyc=%0d act=%0h prec=%0d w=%0b expected cyc=%0d act=%0h prec=%0d w=%0b",
                      cyc, mul_act, mul_prec, mul_w, e[EW-1 -: 16], e[ACT_WIDTH+4 -: ACT_WIDTH], e[4:1], e[0]);
      end
    end
    if (op_done) begin
      n_total++;
      if (done_q.size() == 0) begin
        $display("FAIL op_done: unexpected pulse at cycle %0d", cyc);
      end else begin
        d = done_q.pop_front();
        if (16'(cyc) === d) n_pass++;
        else $display("FAIL op_done: got cycle %0d expected cycle %0d", cyc, d);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at a negedge with in_valid still high so
  // consecutive offers are continuous. acc = cycle number of the accept edge.
  task automatic offer(input logic [15:0] act, input logic [7:0] w, input logic [3:0] prec, output int acc);
    in_act   = act;
    in_w     = w;
    in_prec  = prec;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin
      n_total++;
      $display("FAIL offer_timeout: in_ready stayed 0 expected 1");
      acc = -1;
    end else begin
      acc = cyc + 1;
      @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic drop_valid();
    in_valid = 1'b0;
    in_act   = '0;
    in_w     = '0;
    in_prec  = '0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 200; i++) begin
      if (!busy && exp_q.size() == 0 && done_q.size() == 0) break;
      @(negedge clk);
    end
    if (i == 200) begin
      n_total++;
      $display("FAIL wait_idle: busy=%0b beats_left=%0d dones_left=%0d expected 0", busy, exp_q.size(), done_q.size());
    end
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a;
    int acc;
    rst = 1'b1;
    drop_valid();
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset values
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_mul_valid", mul_valid, 0);
    chk("rst_mul_act",   mul_act,   0);
    chk("rst_mul_w",     mul_w,     0);
    chk("rst_mul_prec",  mul_prec,  0);
    chk("rst_op_done",   op_done,   0);
    chk("rst_busy",      busy,      0);
    chk("rst_prec_err",  prec_err,  0);
    rst = 1'b0;
    @(negedge clk);

    // Single operation: 4'b1011 -> bits 1,0,1,1
    a = cyc + 1;
    exp_op(a + 1, 16'h3C00, 8'h0B, 4);
    offer(16'h3C00, 8'h0B, 4'd4, acc);
    drop_valid();
    chk("single_acc", acc, a);
    chk("single_busy", busy, 1);
    wait_idle();
    chk("single_prec_err", prec_err, 0);

    // Back-to-back, prec 4: A a+1..a+4, B a+5..a+8, C a+9..a+12;
    // C refused at the pop edge a+5, accepted at a+6.
    a = cyc + 1;
    exp_op(a + 1, 16'h1111, 8'h05, 4);
    exp_op(a + 5, 16'h2222, 8'h0C, 4);
    exp_op(a + 9, 16'h3333, 8'h09, 4);
    offer(16'h1111, 8'h05, 4'd4, acc);
    chk("b2b_acc_a", acc, a);
    offer(16'h2222, 8'h0C, 4'd4, acc);
    chk("b2b_acc_b", acc, a + 1);
    chk("b2b_full_ready", in_ready, 0);
    offer(16'h3333, 8'h09, 4'd4, acc);
    drop_valid();
    chk("b2b_acc_c", acc, a + 6);
    wait_idle();

    // Precision change: 1,0,1,0, one bubble at a+5, then 0,1 at prec 2
    a = cyc + 1;
    exp_op(a + 1, 16'h4000, 8'h0A, 4);
    exp_op(a + 6, 16'h4400, 8'h01, 2);
    offer(16'h4000, 8'h0A, 4'd4, acc);
    chk("gap_acc_a", acc, a);
    offer(16'h4400, 8'h01, 4'd2, acc);
    drop_valid();
    chk("gap_acc_b", acc, a + 1);
    wait_idle();

    // Clamp: prec 0 -> 2 (bits 0,1), prec 12 -> 8 (8'h96), gap at a+3
    chk("clamp_err_before", prec_err, 0);
    a = cyc + 1;
    exp_op(a + 1, 16'h1234, 8'h01, 2);
    exp_op(a + 4, 16'h5678, 8'h96, 8);
    offer(16'h1234, 8'h01, 4'd0, acc);
    chk("clamp_acc_a", acc, a);
    chk("clamp_err_set", prec_err, 1);
    offer(16'h5678, 8'h96, 4'd12, acc);
    drop_valid();
    chk("clamp_acc_b", acc, a + 1);
    wait_idle();
    chk("clamp_err_sticky", prec_err, 1);

    // Reset mid-stream: first three beats of an 8-bit op, queued op discarded
    a = cyc + 1;
    for (int k = 0; k < 3; k++)
      exp_q.push_back({16'(a + 1 + k), 16'h7777, 4'd8, 1'b1});
    offer(16'h7777, 8'hFF, 4'd8, acc);
    offer(16'h8888, 8'h55, 4'd8, acc);
    drop_valid();
    @(negedge clk);          // cycle a+2
    @(negedge clk);          // cycle a+3
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_mul_valid", mul_valid, 0);
    chk("mid_rst_in_ready",  in_ready,  1);
    chk("mid_rst_busy",      busy,      0);
    chk("mid_rst_op_done",   op_done,   0);
    chk("mid_rst_prec_err",  prec_err,  0);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_q_drained", exp_q.size(), 0);
    @(negedge clk);

    // Clean restart after reset: 3'b110 -> bits 1,1,0
    a = cyc + 1;
    exp_op(a + 1, 16'hBC00, 8'h06, 3);
    offer(16'hBC00, 8'h06, 4'd3, acc);
    drop_valid();
    chk("restart_acc", acc, a);
    wait_idle();

    chk("end_beats_left", exp_q.size(), 0);
    chk("end_dones_left", done_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
